// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster scan output bundle shared by timing generator and renderers
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/blank decode and renderer-aligned delay line
module vga_timing_gen #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 2
) (
  input  logic             vga_clk,
  input  logic             Reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // 11-bit constants so a 1024-wide raster still compares without overflow
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_L = 11'(H_VIS);
  localparam logic [10:0] V_VIS_L = 11'(V_VIS);
  localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);

  // Idle {hs, vs, blank}: syncs deasserted (high), no active video
  localparam logic [2:0] IDLE = 3'b110;

  // Reject rasters the 10-bit counters cannot hold and delay lines beyond 7 stages
  generate
    if (H_TOTAL > 1024) begin : g_h_err
      $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_err
      $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if (PIPE_DLY > 7) begin : g_d_err
      $error("vga_timing_gen: PIPE_DLY exceeds 7");
    end
  endgenerate

  logic [9:0]  hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [7:0]  fc_q, fc_d;
  logic [10:0] hc_w, vc_w;
  logic        h_wrap, v_wrap;
  logic        act, hs_n, vs_n;
  logic [2:0]  pre_sig;
  logic [2:0]  post_sig;

  assign hc_w = {1'b0, hc_q};
  assign vc_w = {1'b0, vc_q};

  // Next-state for the column/line/frame counters; the frame count only moves on a full frame wrap
  always_comb begin
    h_wrap = (hc_w == H_LAST);
    v_wrap = (vc_w == V_LAST);
    hc_d   = hc_q + 10'd1;
    vc_d   = vc_q;
    fc_d   = fc_q;
    if (h_wrap) begin
      hc_d = '0;
      if (v_wrap) begin
        vc_d = '0;
        fc_d = fc_q + 8'd1;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end
  end

  // Counter registers; async reset returns the scan to the top-left corner
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      hc_q <= '0;
      vc_q <= '0;
      fc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      fc_q <= fc_d;
    end
  end

  // Undelayed sync/active decode; vs depends only on vc so it can only move when hc wraps to 0
  always_comb begin
    act  = (hc_w < H_VIS_L) && (vc_w < V_VIS_L);
    hs_n = !((hc_w >= HS_BEG) && (hc_w < HS_END));
    vs_n = !((vc_w >= VS_BEG) && (vc_w < VS_END));
  end

  assign pre_sig = {hs_n, vs_n, act};

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      // No delay stages: outputs track the counters, held idle while in reset
      assign post_sig = Reset ? IDLE : pre_sig;
    end else begin : g_dly
      logic [2:0] dly_q [PIPE_DLY];
      logic [2:0] dly_d [PIPE_DLY];

      // Shift {hs,vs,blank} one stage per clock so it lines up with the renderers' colour output
      always_comb begin
        dly_d[0] = pre_sig;
        for (int i = 1; i < PIPE_DLY; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end

      // Delay-line registers; every stage reloads idle so no stale sync escapes after reset
      always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            dly_q[i] <= IDLE;
          end
        end else begin
          for (int i = 0; i < PIPE_DLY; i++) begin
            dly_q[i] <= dly_d[i];
          end
        end
      end

      assign post_sig = dly_q[PIPE_DLY-1];
    end
  endgenerate

  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.hs          = post_sig[2];
  assign vga.vs          = post_sig[1];
  assign vga.blank       = post_sig[0];
  assign vga.line_start  = !Reset && (hc_q == 10'd0);
  assign vga.frame_start = !Reset && (hc_q == 10'd0) && (vc_q == 10'd0);
  assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen on reduced rasters
module tb_vga_timing_gen;

  // Instance A: small raster with the default 2-cycle delay
  localparam int AHV = 16, AHF = 2, AHS = 4, AHB = 3;
  localparam int AVV = 8,  AVF = 2, AVS = 2, AVB = 3;
  localparam int AHT = AHV + AHF + AHS + AHB;   // 25
  localparam int AVT = AVV + AVF + AVS + AVB;   // 15
  localparam int AFR = AHT * AVT;               // 375
  localparam int AD  = 2;

  // Instance B: tiny raster, no delay, for the 256-frame wrap
  localparam int BHV = 4, BHF = 1, BHS = 2, BHB = 1;
  localparam int BVV = 3, BVF = 1, BVS = 1, BVB = 1;
  localparam int BHT = BHV + BHF + BHS + BHB;   // 8
  localparam int BVT = BVV + BVF + BVS + BVB;   // 6
  localparam int BFR = BHT * BVT;               // 48

  // {DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count}
  localparam logic [32:0] RST_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  int m_hc, m_vc, m_fc, m_since;
  int n_hc, n_vc, n_fc;

  vga_timing_gen_if ifa ();
  vga_timing_gen_if ifb ();

  vga_timing_gen #(
    .H_VIS(AHV), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_VIS(AVV), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .PIPE_DLY(AD)
  ) dut_a (
    .vga_clk (clk),
    .Reset   (rst_a),
    .vga     (ifa)
  );

  vga_timing_gen #(
    .H_VIS(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_VIS(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .PIPE_DLY(0)
  ) dut_b (
    .vga_clk (clk),
    .Reset   (rst_b),
    .vga     (ifb)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] a_obs();
    return {ifa.DrawX, ifa.DrawY, ifa.hs, ifa.vs, ifa.blank,
            ifa.line_start, ifa.frame_start, ifa.frame_count};
  endfunction

  function automatic logic [32:0] b_obs();
    return {ifb.DrawX, ifb.DrawY, ifb.hs, ifb.vs, ifb.blank,
            ifb.line_start, ifb.frame_start, ifb.frame_count};
  endfunction

  // Expected A outputs: syncs/blank are the decode of the position AD pixels earlier
  function automatic logic [32:0] a_exp(int h, int v, int fc, int since);
    int p, bh, bv;
    logic e_hs, e_vs, e_bl;
    if (since < AD) begin
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0;
    end else begin
      p    = (v * AHT + h - AD + AFR) % AFR;
      bh   = p % AHT;
      bv   = p / AHT;
      e_hs = !(bh >= AHV + AHF && bh < AHV + AHF + AHS);
      e_vs = !(bv >= AVV + AVF && bv < AVV + AVF + AVS);
      e_bl = (bh < AHV) && (bv < AVV);
    end
    return {10'(h), 10'(v), e_hs, e_vs, e_bl, (h == 0), (h == 0 && v == 0), 8'(fc)};
  endfunction

  function automatic logic [32:0] b_exp(int h, int v, int fc);
    logic e_hs, e_vs, e_bl;
    e_hs = !(h >= BHV + BHF && h < BHV + BHF + BHS);
    e_vs = !(v >= BVV + BVF && v < BVV + BVF + BVS);
    e_bl = (h < BHV) && (v < BVV);
    return {10'(h), 10'(v), e_hs, e_vs, e_bl, (h == 0), (h == 0 && v == 0), 8'(fc)};
  endfunction

  task automatic a_adv();
    m_since++;
    m_hc++;
    if (m_hc == AHT) begin
      m_hc = 0;
      m_vc++;
      if (m_vc == AVT) begin
        m_vc = 0;
        m_fc = (m_fc + 1) % 256;
      end
    end
  endtask

  task automatic b_adv();
    n_hc++;
    if (n_hc == BHT) begin
      n_hc = 0;
      n_vc++;
      if (n_vc == BVT) begin
        n_vc = 0;
        n_fc = (n_fc + 1) % 256;
      end
    end
  endtask

  // Reset A for two cycles, release between edges, leave the bench in the first post-reset cycle
  task automatic a_reset();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    m_hc = 0; m_vc = 0; m_fc = 0; m_since = 0;
    #1;
  endtask

  task automatic test_reset();
    logic [32:0] obs;
    rst_a = 1'b1;
    repeat (5) @(negedge clk);
    obs = a_obs();
    tests_run++;
    if (obs !== RST_VEC) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected %h", obs, RST_VEC);
    end
    rst_a = 1'b0;
    m_hc = 0; m_vc = 0; m_fc = 0; m_since = 0;
    #1;
    obs = a_obs();
    tests_run++;
    if (obs !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("FAIL reset_cycle0: got %h expected %h", obs,
               {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0});
    end
    @(negedge clk); a_adv();
    obs = a_obs();
    tests_run++;
    if (obs !== {10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL reset_cycle1: got %h expected %h", obs,
               {10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    end
    @(negedge clk); a_adv();
    obs = a_obs();
    tests_run++;
    if (obs !== {10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL reset_cycle2_blank: got %h expected %h", obs,
               {10'd2, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
    end
  endtask

  task automatic test_line();
    logic [32:0] obs, exp;
    int ls_cnt, hs_lo, fall_x;
    logic prev_hs;
    ls_cnt = 0; hs_lo = 0; fall_x = -1; prev_hs = 1'b1;
    a_reset();
    for (int n = 0; n < 2 * AHT; n++) begin
      if (n > 0) begin
        @(negedge clk); a_adv();
      end
      obs = a_obs();
      exp = a_exp(m_hc, m_vc, m_fc, m_since);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL line_cycle%0d: got %h expected %h", n, obs, exp);
      end
      if (ifa.line_start === 1'b1) ls_cnt++;
      if (n < AHT && ifa.hs === 1'b0) hs_lo++;
      if (fall_x < 0 && prev_hs === 1'b1 && ifa.hs === 1'b0) fall_x = int'(ifa.DrawX);
      prev_hs = ifa.hs;
      if (n == AHT) begin
        tests_run++;
        if (ifa.DrawX !== 10'd0 || ifa.DrawY !== 10'd1) begin
          tests_failed++;
          $display("FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", ifa.DrawX, ifa.DrawY);
        end
      end
    end
    tests_run++;
    if (ls_cnt !== 2) begin
      tests_failed++;
      $display("FAIL line_start_count: got %0d expected 2", ls_cnt);
    end
    tests_run++;
    if (hs_lo !== 4) begin
      tests_failed++;
      $display("FAIL hs_low_width: got %0d expected 4", hs_lo);
    end
    tests_run++;
    if (fall_x !== 20) begin
      tests_failed++;
      $display("FAIL hs_fall_drawx: got %0d expected 20", fall_x);
    end
  endtask

  task automatic test_frame();
    logic [32:0] obs, exp;
    int vs_lo, fs_cnt, fall_x, fall_y;
    logic prev_vs;
    vs_lo = 0; fs_cnt = 0; fall_x = -1; fall_y = -1; prev_vs = 1'b1;
    a_reset();
    for (int n = 0; n <= AFR + AD; n++) begin
      if (n > 0) begin
        @(negedge clk); a_adv();
      end
      obs = a_obs();
      exp = a_exp(m_hc, m_vc, m_fc, m_since);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL frame_cycle%0d: got %h expected %h", n, obs, exp);
      end
      if (n < AFR && ifa.vs === 1'b0) vs_lo++;
      if (n < AFR && ifa.frame_start === 1'b1) fs_cnt++;
      if (fall_x < 0 && prev_vs === 1'b1 && ifa.vs === 1'b0) begin
        fall_x = int'(ifa.DrawX);
        fall_y = int'(ifa.DrawY);
      end
      prev_vs = ifa.vs;
      if (n == AFR - 1) begin
        tests_run++;
        if (ifa.frame_count !== 8'd0 || ifa.DrawX !== 10'd24 || ifa.DrawY !== 10'd14) begin
          tests_failed++;
          $display("FAIL frame_last_pixel: got fc=%0d x=%0d y=%0d expected 0 24 14",
                   ifa.frame_count, ifa.DrawX, ifa.DrawY);
        end
      end
      if (n == AFR) begin
        tests_run++;
        if (ifa.frame_count !== 8'd1 || ifa.DrawY !== 10'd0 || ifa.frame_start !== 1'b1) begin
          tests_failed++;
          $display("FAIL frame_wrap: got fc=%0d y=%0d fs=%b expected 1 0 1",
                   ifa.frame_count, ifa.DrawY, ifa.frame_start);
        end
      end
    end
    tests_run++;
    if (vs_lo !== 50) begin
      tests_failed++;
      $display("FAIL vs_low_width: got %0d expected 50", vs_lo);
    end
    tests_run++;
    if (fs_cnt !== 1) begin
      tests_failed++;
      $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
    end
    tests_run++;
    if (fall_x !== 2 || fall_y !== 10) begin
      tests_failed++;
      $display("FAIL vs_fall_pos: got x=%0d y=%0d expected x=2 y=10", fall_x, fall_y);
    end
  endtask

  task automatic test_blank_count();
    int bl_cnt;
    bl_cnt = 0;
    a_reset();
    for (int n = 1; n < AFR + AD; n++) begin
      @(negedge clk); a_adv();
      if (n >= AD && ifa.blank === 1'b1) bl_cnt++;
    end
    tests_run++;
    if (bl_cnt !== AHV * AVV) begin
      tests_failed++;
      $display("FAIL blank_count: got %0d expected %0d", bl_cnt, AHV * AVV);
    end
  endtask

  task automatic test_midreset();
    logic [32:0] obs, exp;
    a_reset();
    for (int n = 1; n <= 2 * AFR + 5 * AHT + 10; n++) begin
      @(negedge clk); a_adv();
      obs = a_obs();
      exp = a_exp(m_hc, m_vc, m_fc, m_since);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL midrst_run%0d: got %h expected %h", n, obs, exp);
      end
    end
    tests_run++;
    if (ifa.DrawX !== 10'd10 || ifa.DrawY !== 10'd5 || ifa.frame_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL midrst_position: got x=%0d y=%0d fc=%0d expected 10 5 2",
               ifa.DrawX, ifa.DrawY, ifa.frame_count);
    end
    #2 rst_a = 1'b1;
    #1 obs = a_obs();
    tests_run++;
    if (obs !== RST_VEC) begin
      tests_failed++;
      $display("FAIL midrst_async: got %h expected %h", obs, RST_VEC);
    end
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    m_hc = 0; m_vc = 0; m_fc = 0; m_since = 0;
    #1 obs = a_obs();
    tests_run++;
    if (obs !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("FAIL midrst_restart: got %h expected %h", obs,
               {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0});
    end
    // Reset on the very last pixel of a frame must not leave a partial frame count behind
    repeat (AFR - 1) begin
      @(negedge clk); a_adv();
    end
    #2 rst_a = 1'b1;
    #1 obs = a_obs();
    tests_run++;
    if (obs !== RST_VEC) begin
      tests_failed++;
      $display("FAIL midrst_last_pixel: got %h expected %h", obs, RST_VEC);
    end
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ifa.frame_count !== 8'd0 || ifa.DrawX !== 10'd1) begin
      tests_failed++;
      $display("FAIL midrst_no_partial: got fc=%0d x=%0d expected 0 1",
               ifa.frame_count, ifa.DrawX);
    end
  endtask

  task automatic test_pipe0();
    logic [32:0] obs, exp;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    n_hc = 0; n_vc = 0; n_fc = 0;
    #1;
    for (int n = 0; n <= 256 * BFR; n++) begin
      if (n > 0) begin
        @(negedge clk); b_adv();
      end
      obs = b_obs();
      exp = b_exp(n_hc, n_vc, n_fc);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL pipe0_cycle%0d: got %h expected %h", n, obs, exp);
      end
      if (n == 255 * BFR) begin
        tests_run++;
        if (ifb.frame_count !== 8'd255) begin
          tests_failed++;
          $display("FAIL pipe0_fc255: got %0d expected 255", ifb.frame_count);
        end
      end
      if (n == 256 * BFR) begin
        tests_run++;
        if (ifb.frame_count !== 8'd0 || ifb.frame_start !== 1'b1) begin
          tests_failed++;
          $display("FAIL pipe0_fc_wrap: got fc=%0d fs=%b expected 0 1",
                   ifb.frame_count, ifb.frame_start);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_blank_count();
    test_midreset();
    test_pipe0();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
